adc_capture: RTL and testbench

Parametrised ADC front-end in the `clk_PSRAM` domain. It detects falling edges of the free-running `clk_ADC`, discards the converter's pipeline warm-up words, optionally block-averages power-of-two groups of samples, and buffers results in a small FIFO. Downstream logic, typically the PSRAM write path, drains the FIFO through a valid/ready handshake. This block replaces single-pulse `adc_ready` capture with back-pressure, decimation, over-range tracking and overflow reporting.

---
 rtl/adc_pkg.sv | 22 ++
 rtl/adc_sync_fifo.sv | 63 ++++++
 rtl/adc_capture.sv | 213 +++++++++++++++++++++
 tb/tb_adc_capture.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC capture front-end.
package adc_pkg;

    // Capture controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } adc_state_t;

    // Default parameter values for adc_capture.
    localparam int unsigned DATA_W_DEF     = 12;
    localparam int unsigned WARMUP_DEF     = 13;
    localparam int unsigned DECIM_LOG2_DEF = 0;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding {otr, data} results.
module adc_sync_fifo
    import adc_pkg::*;
#(
    parameter int unsigned W     = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [W-1:0]                i_din,
    input  logic                        i_pop,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [level_w(DEPTH)-1:0]   o_level,
    output logic [W-1:0]                o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          w_pop;
    logic          w_push;

    // A pop needs data; a push needs room, which a same-cycle pop provides.
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture.sv
// ADC capture: clk_ADC falling-edge detect, warm-up discard, block averaging, result FIFO.
module adc_capture
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned WARMUP     = WARMUP_DEF,
    parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                              clk_PSRAM,
    input  logic                              rst,
    input  logic                              clk_ADC,
    input  logic [DATA_W-1:0]                 adc_out,
    input  logic                              adc_OTR,
    input  logic                              adc_enable,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_otr,
    output logic                              overflow,
    output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level
);

    localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;
    localparam int unsigned GRP   = 1 << DECIM_LOG2;
    localparam int unsigned GCW   = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam int unsigned WCW   = 8;
    localparam int unsigned FW    = DATA_W + 1;

    // Synchronizer and aligned data pipeline.
    logic              r_clk_s1;
    logic              r_clk_s2;
    logic              r_clk_edge;
    logic [DATA_W-1:0] r_dat_s1;
    logic [DATA_W-1:0] r_dat_s2;
    logic              r_otr_s1;
    logic              r_otr_s2;
    logic              r_fall;
    logic [DATA_W-1:0] r_fall_dat;
    logic              r_fall_otr;

    // Controller and accumulator.
    adc_state_t        r_state;
    adc_state_t        w_state_nxt;
    logic [WCW-1:0]    r_warm_cnt;
    logic [GCW-1:0]    r_grp_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic              r_otr_acc;
    logic              r_en_d;
    logic              r_overflow;

    logic              w_fall;
    logic              w_warm_last;
    logic              w_grp_last;
    logic [ACC_W-1:0]  w_sum;
    logic              w_push;
    logic [FW-1:0]     w_push_word;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic [FW-1:0]     w_head;

    // Falling edge of the synchronized ADC clock.
    assign w_fall      = r_clk_edge && !r_clk_s2;
    assign w_warm_last = (r_warm_cnt == WCW'(WARMUP - 1));
    assign w_grp_last  = (r_grp_cnt == GCW'(GRP - 1));
    assign w_sum       = r_acc + ACC_W'(r_fall_dat);
    assign w_push_word = {r_otr_acc | r_fall_otr, DATA_W'(w_sum >> DECIM_LOG2)};

    // Two-flop clk_ADC synchronizer, edge register and matching data delay.
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_edge <= 1'b0;
            r_dat_s1   <= '0;
            r_dat_s2   <= '0;
            r_otr_s1   <= 1'b0;
            r_otr_s2   <= 1'b0;
            r_fall     <= 1'b0;
            r_fall_dat <= '0;
            r_fall_otr <= 1'b0;
        end else begin
            r_clk_s1   <= clk_ADC;
            r_clk_s2   <= r_clk_s1;
            r_clk_edge <= r_clk_s2;
            r_dat_s1   <= adc_out;
            r_dat_s2   <= r_dat_s1;
            r_otr_s1   <= adc_OTR;
            r_otr_s2   <= r_otr_s1;
            r_fall     <= w_fall;
            r_fall_dat <= r_dat_s2;
            r_fall_otr <= r_otr_s2;
        end
    end

    // Controller state register.
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and push decode; enable low always falls back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (adc_enable) begin
                    w_state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!adc_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_fall && w_warm_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!adc_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_fall && w_grp_last) begin
                    w_push = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Warm-up counter, group counter and accumulator; idle wipes all progress.
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_grp_cnt  <= '0;
            r_acc      <= '0;
            r_otr_acc  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_WARMUP: begin
                    if (adc_enable && r_fall) begin
                        r_warm_cnt <= r_warm_cnt + WCW'(1);
                    end
                end
                ST_RUN: begin
                    if (adc_enable && r_fall) begin
                        if (w_grp_last) begin
                            r_acc     <= '0;
                            r_otr_acc <= 1'b0;
                            r_grp_cnt <= '0;
                        end else begin
                            r_acc     <= w_sum;
                            r_otr_acc <= r_otr_acc | r_fall_otr;
                            r_grp_cnt <= r_grp_cnt + GCW'(1);
                        end
                    end
                end
                default: begin
                    r_warm_cnt <= '0;
                    r_grp_cnt  <= '0;
                    r_acc      <= '0;
                    r_otr_acc  <= 1'b0;
                end
            endcase
        end
    end

    // A result is lost when the FIFO is full and nothing leaves this cycle.
    assign w_pop  = out_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    // Sticky overflow, cleared by reset or a fresh enable.
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_en_d     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_en_d <= adc_enable;
            if (adc_enable && !r_en_d) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    adc_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_PSRAM),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_word),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_head  (w_head)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_head[DATA_W-1:0];
    assign out_otr   = w_head[DATA_W];
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: warm-up, averaging, OTR, overflow, enable drop.
`timescale 1ns/1ps
module tb_adc_capture;
    import adc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_adc;
    logic [11:0] adc_dat;
    logic        adc_otr;
    logic        en;
    logic        rdy_a, rdy_b, rdy_c;

    logic        va, vb, vc;
    logic [11:0] da, db, dc;
    logic        oa, ob, oc;
    logic        ova, ovb, ovc;
    logic [3:0]  la, lb, lc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Default build: 13 warm-up edges, passthrough.
    adc_capture #(.DATA_W(12), .WARMUP(13), .DECIM_LOG2(0), .FIFO_DEPTH(8)) dut_a (
        .clk_PSRAM(clk), .rst(rst), .clk_ADC(clk_adc), .adc_out(adc_dat), .adc_OTR(adc_otr),
        .adc_enable(en), .out_valid(va), .out_ready(rdy_a), .out_data(da), .out_otr(oa),
        .overflow(ova), .fifo_level(la));

    // No warm-up, groups of four.
    adc_capture #(.DATA_W(12), .WARMUP(0), .DECIM_LOG2(2), .FIFO_DEPTH(8)) dut_b (
        .clk_PSRAM(clk), .rst(rst), .clk_ADC(clk_adc), .adc_out(adc_dat), .adc_OTR(adc_otr),
        .adc_enable(en), .out_valid(vb), .out_ready(rdy_b), .out_data(db), .out_otr(ob),
        .overflow(ovb), .fifo_level(lb));

    // Two warm-up edges, groups of four.
    adc_capture #(.DATA_W(12), .WARMUP(2), .DECIM_LOG2(2), .FIFO_DEPTH(8)) dut_c (
        .clk_PSRAM(clk), .rst(rst), .clk_ADC(clk_adc), .adc_out(adc_dat), .adc_OTR(adc_otr),
        .adc_enable(en), .out_valid(vc), .out_ready(rdy_c), .out_data(dc), .out_otr(oc),
        .overflow(ovc), .fifo_level(lc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clk_ADC period (10 fast cycles); the word is stable across the falling edge.
    task automatic sample(input logic [11:0] v, input logic o);
        adc_dat = v;
        adc_otr = o;
        clk_adc = 1'b1;
        cyc(5);
        clk_adc = 1'b0;
        cyc(5);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        rdy_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_adc = ~clk_adc;
            @(negedge clk);
            chk("rst_valid", 32'(va), 32'd0);
            chk("rst_data", 32'(da), 32'd0);
            chk("rst_otr", 32'(oa), 32'd0);
            chk("rst_overflow", 32'(ova), 32'd0);
            chk("rst_level", 32'(la), 32'd0);
        end
        clk_adc = 1'b0;
        rst     = 1'b0;
        cyc(3);
    endtask

    // Check the head word of one instance, then pop it with a one-cycle ready pulse.
    task automatic pop(input int which, input string tag, input logic [11:0] ed, input logic eo);
        logic        v;
        logic [11:0] d;
        logic        o;
        case (which)
            0:       begin v = va; d = da; o = oa; end
            1:       begin v = vb; d = db; o = ob; end
            default: begin v = vc; d = dc; o = oc; end
        endcase
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_data"}, 32'(d), 32'(ed));
        chk({tag, "_otr"}, 32'(o), 32'(eo));
        case (which)
            0:       rdy_a = 1'b1;
            1:       rdy_b = 1'b1;
            default: rdy_c = 1'b1;
        endcase
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        rdy_c = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        clk_adc = 1'b0;
        adc_dat = '0;
        adc_otr = 1'b0;
        rdy_a   = 1'b0;
        rdy_b   = 1'b0;
        rdy_c   = 1'b0;
        @(negedge clk);

        // Warm-up discard on a ramp, exact first-result latency, then in-order drain.
        do_reset();
        for (int v = 0; v < 13; v++) begin
            sample(12'(v), 1'b0);
            chk("a_warm_valid", 32'(va), 32'd0);
        end
        adc_dat = 12'd13;
        adc_otr = 1'b0;
        clk_adc = 1'b1;
        cyc(5);
        clk_adc = 1'b0;
        cyc(3);
        chk("a_lat_k2_valid", 32'(va), 32'd0);
        cyc(1);
        chk("a_lat_k3_valid", 32'(va), 32'd1);
        chk("a_lat_k3_data", 32'(da), 32'd13);
        cyc(1);
        for (int v = 14; v <= 20; v++) begin
            sample(12'(v), 1'b0);
        end
        chk("a_full_level", 32'(la), 32'd8);
        chk("a_no_overflow", 32'(ova), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pop(0, "a_ramp", 12'(13 + i), 1'b0);
        end
        chk("a_drained_valid", 32'(va), 32'd0);
        chk("a_drained_level", 32'(la), 32'd0);

        // Averaging, full-scale without wrap, and OTR tracking per group.
        do_reset();
        for (int v = 100; v <= 103; v++) sample(12'(v), 1'b0);
        cyc(2);
        chk("b_hold_data", 32'(db), 32'd101);
        pop(1, "b_avg", 12'd101, 1'b0);
        for (int i = 0; i < 4; i++) sample(12'd4095, 1'b0);
        pop(1, "b_max", 12'd4095, 1'b0);
        sample(12'd10, 1'b0);
        sample(12'd20, 1'b0);
        sample(12'd30, 1'b1);
        sample(12'd40, 1'b0);
        pop(1, "b_otr_set", 12'd25, 1'b1);
        for (int v = 1; v <= 4; v++) sample(12'(v), 1'b0);
        pop(1, "b_otr_clr", 12'd2, 1'b0);

        // Back-pressure: ten results into depth eight, drop the last two.
        do_reset();
        for (int g = 1; g <= 10; g++) begin
            for (int s = 0; s < 4; s++) sample(12'(g), 1'b0);
        end
        chk("b_ovf_level", 32'(lb), 32'd8);
        chk("b_ovf_flag", 32'(ovb), 32'd1);
        for (int g = 1; g <= 8; g++) begin
            pop(1, "b_drain", 12'(g), 1'b0);
        end
        chk("b_drain_empty", 32'(vb), 32'd0);
        chk("b_ovf_sticky", 32'(ovb), 32'd1);
        en = 1'b0;
        cyc(3);
        chk("b_ovf_en_low", 32'(ovb), 32'd1);
        en = 1'b1;
        cyc(2);
        chk("b_ovf_cleared", 32'(ovb), 32'd0);

        // Enable drop mid-group, then a fresh warm-up and a clean group.
        do_reset();
        sample(12'd7, 1'b0);
        sample(12'd7, 1'b0);
        sample(12'd50, 1'b0);
        sample(12'd60, 1'b0);
        en = 1'b0;
        cyc(3);
        chk("c_drop_valid", 32'(vc), 32'd0);
        chk("c_drop_level", 32'(lc), 32'd0);
        chk("c_drop_state", 32'(dut_c.r_state), 32'(ST_IDLE));
        en = 1'b1;
        cyc(2);
        sample(12'd200, 1'b0);
        sample(12'd201, 1'b0);
        sample(12'd8, 1'b0);
        sample(12'd8, 1'b0);
        sample(12'd8, 1'b0);
        chk("c_partial_valid", 32'(vc), 32'd0);
        sample(12'd12, 1'b0);
        pop(2, "c_fresh", 12'd9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
